// File: rtl/core_sleep_ctrl.sv
// Core sleep sequencer: drains the core, gates its clock while asleep and
// re-enables fetch a fixed number of cycles after a wake condition.
module core_sleep_ctrl #(
  parameter int WAKE_DELAY  = 4,
  parameter int IDLE_CYCLES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 sleep_req_i,
  input  logic                 irq_i,
  input  logic                 wake_event_i,
  input  logic                 core_busy_i,
  output logic                 core_clk_en_o,
  output logic                 core_fetch_en_o,
  output logic                 wakeup_o,
  output logic [1:0]           sleep_state_o,
  output logic [CNT_WIDTH-1:0] sleep_cycles_o
);

  localparam int IDLE_EFF = (IDLE_CYCLES < 1) ? 1 : IDLE_CYCLES;
  localparam int WAKE_EFF = (WAKE_DELAY < 1) ? 1 : WAKE_DELAY;
  localparam int IW       = $clog2(IDLE_EFF + 1);
  localparam int WW       = (WAKE_EFF > 1) ? $clog2(WAKE_EFF) : 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SLEEP = 2'd2,
    ST_WAKE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [IW-1:0]         r_idle_cnt;
  logic [WW-1:0]         r_wake_cnt;
  logic [CNT_WIDTH-1:0]  r_sleep_cnt;
  logic                  r_clk_en;
  logic                  r_fetch_en;
  logic                  r_wakeup;

  logic                  w_wake;
  logic                  w_sleep_go;
  logic [IW-1:0]         w_idle_inc;
  logic                  w_idle_done;
  logic                  w_cnt_sat;

  assign w_wake      = irq_i | wake_event_i | ~sleep_req_i;
  assign w_sleep_go  = sleep_req_i & ~irq_i & ~wake_event_i;
  assign w_idle_inc  = r_idle_cnt + IW'(1);
  // The idle run completes on the cycle whose increment would reach the target.
  assign w_idle_done = ~core_busy_i & (w_idle_inc == IW'(IDLE_EFF));
  assign w_cnt_sat   = &r_sleep_cnt;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= ST_RUN;
      r_idle_cnt  <= '0;
      r_wake_cnt  <= '0;
      r_sleep_cnt <= '0;
      r_clk_en    <= 1'b1;
      r_fetch_en  <= 1'b1;
      r_wakeup    <= 1'b0;
    end else begin
      r_wakeup <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_sleep_go) begin
            r_state    <= ST_DRAIN;
            r_idle_cnt <= '0;
            r_clk_en   <= 1'b1;
            r_fetch_en <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (w_wake) begin
            r_state    <= ST_RUN;
            r_fetch_en <= 1'b1;
          end else if (w_idle_done) begin
            r_state     <= ST_SLEEP;
            r_idle_cnt  <= '0;
            r_sleep_cnt <= '0;
            r_clk_en    <= 1'b0;
          end else if (core_busy_i) begin
            r_idle_cnt <= '0;
          end else begin
            r_idle_cnt <= w_idle_inc;
          end
        end
        ST_SLEEP: begin
          if (!w_cnt_sat) begin
            r_sleep_cnt <= r_sleep_cnt + CNT_WIDTH'(1);
          end
          if (w_wake) begin
            r_state    <= ST_WAKE;
            r_clk_en   <= 1'b1;
            r_wake_cnt <= WW'(WAKE_EFF - 1);
          end
        end
        ST_WAKE: begin
          // Inputs are deliberately ignored here so the wake sequence always completes.
          if (r_wake_cnt == '0) begin
            r_state    <= ST_RUN;
            r_fetch_en <= 1'b1;
            r_wakeup   <= 1'b1;
          end else begin
            r_wake_cnt <= r_wake_cnt - WW'(1);
          end
        end
        default: begin
          r_state    <= ST_RUN;
          r_clk_en   <= 1'b1;
          r_fetch_en <= 1'b1;
        end
      endcase
    end
  end

  assign core_clk_en_o   = r_clk_en;
  assign core_fetch_en_o = r_fetch_en;
  assign wakeup_o        = r_wakeup;
  assign sleep_state_o   = r_state;
  assign sleep_cycles_o  = r_sleep_cnt;

endmodule

// File: tb/tb_core_sleep_ctrl.sv
// Scoreboard bench for core_sleep_ctrl: two configurations share one stimulus
// stream and are checked every cycle against a behavioural model.
module tb_core_sleep_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESET, sleep_req, irq, wake_ev, busy;
  logic        clk_en_a, fetch_en_a, wakeup_a, clk_en_b, fetch_en_b, wakeup_b;
  logic [1:0]  st_a, st_b;
  logic [3:0]  cnt_a;
  logic [15:0] cnt_b;

  core_sleep_ctrl #(.WAKE_DELAY(4), .IDLE_CYCLES(2), .CNT_WIDTH(4)) u_dut_a (
    .HCLK(HCLK), .HRESET(HRESET), .sleep_req_i(sleep_req), .irq_i(irq),
    .wake_event_i(wake_ev), .core_busy_i(busy), .core_clk_en_o(clk_en_a),
    .core_fetch_en_o(fetch_en_a), .wakeup_o(wakeup_a), .sleep_state_o(st_a),
    .sleep_cycles_o(cnt_a)
  );

  core_sleep_ctrl #(.WAKE_DELAY(0), .IDLE_CYCLES(0), .CNT_WIDTH(16)) u_dut_b (
    .HCLK(HCLK), .HRESET(HRESET), .sleep_req_i(sleep_req), .irq_i(irq),
    .wake_event_i(wake_ev), .core_busy_i(busy), .core_clk_en_o(clk_en_b),
    .core_fetch_en_o(fetch_en_b), .wakeup_o(wakeup_b), .sleep_state_o(st_b),
    .sleep_cycles_o(cnt_b)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int st;
    int clk_en;
    int fetch_en;
    int wakeup;
    int cnt;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Model: phase 0..3 = RUN/DRAIN/SLEEP/WAKE, plus plain integer counters.
  int m_st[2], m_idle[2], m_cnt[2], m_wake_left[2], m_wakeup[2];
  int p_idle[2] = '{2, 1};
  int p_wake[2] = '{4, 1};
  int p_max[2]  = '{15, 65535};

  task automatic model_step(input int k, input bit rst, input bit req, input bit i,
                            input bit ev, input bit bsy, output exp_t e);
    bit wake;
    wake = i | ev | !req;
    if (rst) begin
      m_st[k] = 0; m_idle[k] = 0; m_cnt[k] = 0; m_wake_left[k] = 0; m_wakeup[k] = 0;
    end else begin
      m_wakeup[k] = 0;
      if (m_st[k] == 0) begin
        if (req && !i && !ev) begin
          m_st[k] = 1; m_idle[k] = 0;
        end
      end else if (m_st[k] == 1) begin
        if (wake) m_st[k] = 0;
        else begin
          m_idle[k] = bsy ? 0 : m_idle[k] + 1;
          if (m_idle[k] >= p_idle[k]) begin
            m_st[k] = 2; m_cnt[k] = 0; m_idle[k] = 0;
          end
        end
      end else if (m_st[k] == 2) begin
        if (m_cnt[k] < p_max[k]) m_cnt[k]++;
        if (wake) begin
          m_st[k] = 3; m_wake_left[k] = p_wake[k];
        end
      end else begin
        m_wake_left[k]--;
        if (m_wake_left[k] == 0) begin
          m_st[k] = 0; m_wakeup[k] = 1;
        end
      end
    end
    e.st       = m_st[k];
    e.clk_en   = (m_st[k] != 2) ? 1 : 0;
    e.fetch_en = (m_st[k] == 0) ? 1 : 0;
    e.wakeup   = m_wakeup[k];
    e.cnt      = m_cnt[k];
  endtask

  task automatic step(input bit rst, input bit req, input bit i, input bit ev, input bit bsy);
    exp_t e;
    @(negedge HCLK);
    HRESET = rst; sleep_req = req; irq = i; wake_ev = ev; busy = bsy;
    model_step(0, rst, req, i, ev, bsy, e);
    q_a.push_back(e);
    model_step(1, rst, req, i, ev, bsy, e);
    q_b.push_back(e);
  endtask

  task automatic run(input int n, input bit req, input bit i, input bit ev, input bit bsy);
    repeat (n) step(1'b0, req, i, ev, bsy);
  endtask

  task automatic check(input string name, input exp_t e, input int st, input int ce,
                       input int fe, input int wu, input int cnt);
    tests++;
    if (st != e.st || ce != e.clk_en || fe != e.fetch_en || wu != e.wakeup || cnt != e.cnt) begin
      fails++;
      $display("FAIL %s cyc %0d: got st=%0d clk_en=%0d fetch_en=%0d wakeup=%0d cnt=%0d, want st=%0d clk_en=%0d fetch_en=%0d wakeup=%0d cnt=%0d",
               name, cyc, st, ce, fe, wu, cnt, e.st, e.clk_en, e.fetch_en, e.wakeup, e.cnt);
    end
  endtask

  // Monitor: the DUT presents a full output set every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge HCLK);
      #1;
      cyc++;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("dut_a", e, int'(st_a), int'(clk_en_a), int'(fetch_en_a), int'(wakeup_a), int'(cnt_a));
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("dut_b", e, int'(st_b), int'(clk_en_b), int'(fetch_en_b), int'(wakeup_b), int'(cnt_b));
        $display("[TB] cyc %0d req=%0d irq=%0d ev=%0d busy=%0d | a: st=%0d cnt=%0d wk=%0d | b: st=%0d cnt=%0d wk=%0d",
                 cyc, sleep_req, irq, wake_ev, busy, st_a, cnt_a, wakeup_a, st_b, cnt_b, wakeup_b);
      end
    end
  end

  initial begin
    bit rb, rq, ri, re, rbsy;
    HRESET = 1'b1; sleep_req = 1'b0; irq = 1'b0; wake_ev = 1'b0; busy = 1'b0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    // Basic sleep and irq wake
    run(10, 1, 0, 0, 0);
    run(1, 1, 1, 0, 0);
    run(6, 0, 0, 0, 0);
    // Busy stall with a single low glitch, then two idle cycles
    run(1, 1, 0, 0, 1);
    run(1, 1, 0, 0, 1);
    run(1, 1, 0, 0, 0);
    run(3, 1, 0, 0, 1);
    run(3, 1, 0, 0, 0);
    run(6, 0, 0, 0, 0);
    // Drain abort by event pulse with idle count 1
    run(1, 1, 0, 0, 0);
    run(1, 1, 0, 0, 0);
    run(1, 1, 0, 1, 0);
    run(2, 0, 0, 0, 0);
    // Request withdrawn, then reasserted during WAKE
    run(4, 1, 0, 0, 0);
    run(1, 0, 0, 0, 0);
    run(7, 1, 0, 0, 0);
    run(6, 0, 0, 0, 0);
    // Saturation and clear on the next sleep entry
    run(25, 1, 0, 0, 0);
    run(6, 0, 0, 0, 0);
    run(6, 1, 0, 0, 0);
    // Reset in SLEEP and in WAKE
    for (int n = 0; n < 10 && m_st[0] != 2; n++) run(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    for (int n = 0; n < 10 && m_st[0] != 2; n++) run(1, 1, 0, 0, 0);
    run(1, 0, 0, 0, 0);
    for (int n = 0; n < 10 && m_st[0] != 3; n++) run(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    run(3, 0, 0, 0, 0);
    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rb   = ($urandom_range(0, 199) == 0);
      rq   = ($urandom_range(0, 9) < 8);
      ri   = ($urandom_range(0, 24) == 0);
      re   = ($urandom_range(0, 24) == 0);
      rbsy = ($urandom_range(0, 2) == 0);
      step(rb, rq, ri, re, rbsy);
    end
    repeat (3) @(posedge HCLK);
    #2;
    tests++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d/%0d entries left, want 0/0", q_a.size(), q_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
